// File: rtl/varlat_id_fifo.sv
// Small in-order FIFO of master indices for granted bank transactions.
// The head entry is visible combinationally so a response can be routed
// in the same cycle it arrives. Push and pop may coincide at any
// occupancy, including full.
module varlat_id_fifo #(
    parameter int unsigned Width = 2,
    parameter int unsigned Depth = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntWidth = $clog2(Depth) + 1;
    localparam logic [PtrWidth-1:0] LastPtr  = PtrWidth'(Depth - 1);
    localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(Depth);

    logic [Width-1:0]    mem_q [Depth];
    logic [PtrWidth-1:0] wr_ptr_q;
    logic [PtrWidth-1:0] rd_ptr_q;
    logic [CntWidth-1:0] cnt_q;
    logic                do_push;
    logic                do_pop;

    assign full_o  = (cnt_q == DepthCnt);
    assign empty_o = (cnt_q == '0);
    // A push into a full FIFO is only legal when the head leaves this cycle.
    assign do_push = push_i & (~full_o | pop_i);
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    // Storage array; entries need no reset because occupancy gates their use.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointer and occupancy bookkeeping, pointers wrapping at Depth.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

// File: rtl/bank_arb_resp_demux_varlat.sv
// Round-robin arbiter in front of one memory bank, with an in-order ID
// FIFO that steers variable-latency bank responses back to the master
// that was granted. Request path and response path are both combinational.
module bank_arb_resp_demux_varlat #(
    parameter int unsigned NumIn          = 4,
    parameter int unsigned ReqDataWidth   = 32,
    parameter int unsigned RespDataWidth  = 32,
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned LogNumIn       = (NumIn > 1) ? $clog2(NumIn) : 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NumIn-1:0]                     req_i,
    input  logic [NumIn-1:0][ReqDataWidth-1:0]   data_i,
    output logic [NumIn-1:0]                     gnt_o,
    output logic [NumIn-1:0]                     vld_o,
    output logic [NumIn-1:0][RespDataWidth-1:0]  rdata_o,
    output logic                                 req_o,
    input  logic                                 gnt_i,
    output logic [ReqDataWidth-1:0]              data_o,
    input  logic                                 vld_i,
    input  logic [RespDataWidth-1:0]             rdata_i
);
    logic [LogNumIn-1:0] winner;
    logic [LogNumIn-1:0] head_id;
    logic                fifo_full;
    logic                fifo_empty;
    logic                pop;
    logic                accept;
    logic                handshake;

    // A response only counts if some grant is still waiting for it.
    assign pop       = vld_i & ~fifo_empty;
    assign accept    = ~fifo_full | pop;
    assign req_o     = (|req_i) & accept;
    assign handshake = req_o & gnt_i;
    assign data_o    = data_i[winner];

    generate
        if (NumIn > 1) begin : g_arb
            localparam logic [LogNumIn-1:0] LastIdx = LogNumIn'(NumIn - 1);
            logic [LogNumIn-1:0] rr_q;
            logic                found;

            // Pick the first requester at or after rr_q, wrapping to 0.
            always_comb begin
                winner = '0;
                found  = 1'b0;
                for (int k = 0; k < NumIn; k++) begin
                    if (!found && req_i[k] && (LogNumIn'(k) >= rr_q)) begin
                        winner = LogNumIn'(k);
                        found  = 1'b1;
                    end
                end
                for (int k = 0; k < NumIn; k++) begin
                    if (!found && req_i[k]) begin
                        winner = LogNumIn'(k);
                        found  = 1'b1;
                    end
                end
            end

            // Priority moves past the winner only on a completed handshake.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    rr_q <= '0;
                end else if (handshake) begin
                    rr_q <= (winner == LastIdx) ? '0 : winner + 1'b1;
                end
            end
        end else begin : g_single
            assign winner = '0;
        end
    endgenerate

    varlat_id_fifo #(
        .Width (LogNumIn),
        .Depth (MaxOutstanding)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (handshake),
        .data_i  (winner),
        .pop_i   (pop),
        .data_o  (head_id),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    generate
        for (genvar gi = 0; gi < NumIn; gi++) begin : g_port
            assign gnt_o[gi]   = handshake & (winner == LogNumIn'(gi));
            assign vld_o[gi]   = pop & (head_id == LogNumIn'(gi));
            assign rdata_o[gi] = rdata_i;
        end
    endgenerate

    // Simulation checks: legal parameters, orphan responses, one-hot strobes.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (NumIn > 0)
                else $error("NumIn must be at least 1");
            assert ((MaxOutstanding != 0) && ((MaxOutstanding & (MaxOutstanding - 1)) == 0))
                else $error("MaxOutstanding must be a power of two");
            assert (!(vld_i && fifo_empty))
                else $warning("bank response with no outstanding grant dropped");
            assert ($onehot0(gnt_o))
                else $error("more than one grant asserted");
            assert ($onehot0(vld_o))
                else $error("more than one response valid asserted");
        end
    end
endmodule

// File: tb/tb_bank_arb_resp_demux_varlat.sv
// Self-checking bench: a 4-master instance for arbitration, back-pressure
// and reset scenarios, plus a 1-master instance for the bypass case.
// Granted master IDs are queued when stimulus is driven and popped when
// the bank response comes back.
module tb_bank_arb_resp_demux_varlat;
    logic             clk_i = 1'b0;
    logic             rst_ni;

    logic [3:0]       req_i;
    logic [3:0][31:0] data_i;
    logic [3:0]       gnt_o;
    logic [3:0]       vld_o;
    logic [3:0][31:0] rdata_o;
    logic             req_o;
    logic             gnt_i;
    logic [31:0]      data_o;
    logic             vld_i;
    logic [31:0]      rdata_i;

    logic [0:0]       s_req_i;
    logic [0:0][31:0] s_data_i;
    logic [0:0]       s_gnt_o;
    logic [0:0]       s_vld_o;
    logic [0:0][31:0] s_rdata_o;
    logic             s_req_o;
    logic             s_gnt_i;
    logic [31:0]      s_data_o;
    logic             s_vld_i;
    logic [31:0]      s_rdata_i;

    int               n_cmp = 0;
    int               n_bad = 0;
    int               id_q[$];
    int               sq[$];

    always #5 clk_i = ~clk_i;

    bank_arb_resp_demux_varlat #(
        .NumIn(4), .ReqDataWidth(32), .RespDataWidth(32), .MaxOutstanding(2)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .data_i(data_i),
        .gnt_o(gnt_o), .vld_o(vld_o), .rdata_o(rdata_o), .req_o(req_o),
        .gnt_i(gnt_i), .data_o(data_o), .vld_i(vld_i), .rdata_i(rdata_i)
    );

    bank_arb_resp_demux_varlat #(
        .NumIn(1), .ReqDataWidth(32), .RespDataWidth(32), .MaxOutstanding(4)
    ) dut1 (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(s_req_i), .data_i(s_data_i),
        .gnt_o(s_gnt_o), .vld_o(s_vld_o), .rdata_o(s_rdata_o), .req_o(s_req_o),
        .gnt_i(s_gnt_i), .data_o(s_data_o), .vld_i(s_vld_i), .rdata_i(s_rdata_i)
    );

    function automatic logic [31:0] pay(int k, int c);
        return 32'(32'h1000_0000 * (k + 1) + c);
    endfunction

    task automatic set_data(int c);
        for (int k = 0; k < 4; k++) data_i[k] = pay(k, c);
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; req_i = '0; gnt_i = 1'b0; vld_i = 1'b0;
        s_req_i = '0; s_gnt_i = 1'b0; s_vld_i = 1'b0;
        s_data_i[0] = 32'h0; s_rdata_i = 32'h0;
        set_data(7); rdata_i = 32'h5A5A_0001;
        @(negedge clk_i);
        n_cmp++; if (gnt_o !== 4'b0) begin n_bad++; $display("FAIL reset_gnt got=%b want=0000", gnt_o); end
        n_cmp++; if (vld_o !== 4'b0) begin n_bad++; $display("FAIL reset_vld got=%b want=0000", vld_o); end
        n_cmp++; if (req_o !== 1'b0) begin n_bad++; $display("FAIL reset_req got=%b want=0", req_o); end
        n_cmp++; if (data_o !== pay(0, 7)) begin n_bad++; $display("FAIL reset_data got=%h want=%h", data_o, pay(0, 7)); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (rdata_o[k] !== 32'h5A5A_0001) begin n_bad++; $display("FAIL reset_rdata k=%0d got=%h want=5a5a0001", k, rdata_o[k]); end
        end
        $display("reset: gnt=%b vld=%b req=%b", gnt_o, vld_o, req_o);
        next_cycle();
        rst_ni = 1'b1;
    endtask

    // All four masters request with a one-cycle bank latency.
    task automatic test_round_robin();
        int w;
        logic [3:0] eg, ev;
        for (int c = 0; c < 6; c++) begin
            req_i = (c < 5) ? 4'hF : 4'h0;
            gnt_i = 1'b1;
            vld_i = (c > 0);
            rdata_i = 32'(32'hA000_0000 + c);
            set_data(c);
            @(negedge clk_i);
            ev = 4'b0;
            w = 0;
            if (vld_i && id_q.size() > 0) begin w = id_q.pop_front(); ev = 4'b1 << w; end
            n_cmp++; if (vld_o !== ev) begin n_bad++; $display("FAIL rr_vld c=%0d got=%b want=%b", c, vld_o, ev); end
            if (ev != 0) begin
                n_cmp++;
                if (rdata_o[w] !== 32'(32'hA000_0000 + c)) begin n_bad++; $display("FAIL rr_rdata c=%0d got=%h want=%h", c, rdata_o[w], 32'(32'hA000_0000 + c)); end
            end
            eg = (c < 5) ? (4'b1 << (c % 4)) : 4'b0;
            n_cmp++; if (gnt_o !== eg) begin n_bad++; $display("FAIL rr_gnt c=%0d got=%b want=%b", c, gnt_o, eg); end
            if (c < 5) begin
                n_cmp++; if (data_o !== pay(c % 4, c)) begin n_bad++; $display("FAIL rr_data c=%0d got=%h want=%h", c, data_o, pay(c % 4, c)); end
                id_q.push_back(c % 4);
            end
            $display("rr c=%0d gnt=%b vld=%b", c, gnt_o, vld_o);
            next_cycle();
        end
        req_i = '0; gnt_i = 1'b0; vld_i = 1'b0;
    endtask

    // Master 2 waits three cycles for the bank; priority then passes to 3.
    task automatic test_hold_priority();
        logic [3:0] eg;
        int w;
        for (int c = 0; c < 4; c++) begin
            req_i = 4'b0100; gnt_i = (c == 3); vld_i = 1'b0; set_data(20 + c);
            @(negedge clk_i);
            eg = (c == 3) ? 4'b0100 : 4'b0000;
            n_cmp++; if (gnt_o !== eg) begin n_bad++; $display("FAIL hold_gnt c=%0d got=%b want=%b", c, gnt_o, eg); end
            n_cmp++; if (req_o !== 1'b1) begin n_bad++; $display("FAIL hold_req c=%0d got=%b want=1", c, req_o); end
            n_cmp++; if (data_o !== pay(2, 20 + c)) begin n_bad++; $display("FAIL hold_data c=%0d got=%h want=%h", c, data_o, pay(2, 20 + c)); end
            if (c == 3) id_q.push_back(2);
            $display("hold c=%0d gnt=%b req=%b", c, gnt_o, req_o);
            next_cycle();
        end
        req_i = 4'b1101; gnt_i = 1'b1; vld_i = 1'b1; rdata_i = 32'hB0B0_0002;
        @(negedge clk_i);
        w = id_q.pop_front();
        n_cmp++; if (vld_o !== (4'b1 << w)) begin n_bad++; $display("FAIL hold_vld got=%b want=%b", vld_o, 4'b1 << w); end
        n_cmp++; if (gnt_o !== 4'b1000) begin n_bad++; $display("FAIL hold_next_gnt got=%b want=1000", gnt_o); end
        id_q.push_back(3);
        $display("hold next gnt=%b vld=%b", gnt_o, vld_o);
        next_cycle();
        req_i = '0; gnt_i = 1'b0; vld_i = 1'b1;
        @(negedge clk_i);
        w = id_q.pop_front();
        n_cmp++; if (vld_o !== (4'b1 << w)) begin n_bad++; $display("FAIL hold_drain got=%b want=%b", vld_o, 4'b1 << w); end
        $display("hold drain vld=%b", vld_o);
        next_cycle();
        vld_i = 1'b0;
    endtask

    // Two grants fill the FIFO; a third request is held off until responses drain.
    task automatic test_full();
        logic [3:0] rq [4];
        logic [3:0] eg;
        rq = '{4'b0010, 4'b1000, 4'b0100, 4'b0100};
        for (int c = 0; c < 4; c++) begin
            req_i = rq[c]; gnt_i = 1'b1; vld_i = 1'b0; set_data(30 + c);
            @(negedge clk_i);
            eg = (c < 2) ? rq[c] : 4'b0000;
            n_cmp++; if (gnt_o !== eg) begin n_bad++; $display("FAIL full_gnt c=%0d got=%b want=%b", c, gnt_o, eg); end
            n_cmp++; if (req_o !== (c < 2)) begin n_bad++; $display("FAIL full_req c=%0d got=%b want=%b", c, req_o, (c < 2)); end
            if (c == 0) id_q.push_back(1);
            if (c == 1) id_q.push_back(3);
            $display("full c=%0d gnt=%b req=%b", c, gnt_o, req_o);
            next_cycle();
        end
        for (int c = 0; c < 2; c++) begin
            req_i = '0; gnt_i = 1'b0; vld_i = 1'b1;
            @(negedge clk_i);
            eg = 4'b1 << id_q.pop_front();
            n_cmp++; if (vld_o !== eg) begin n_bad++; $display("FAIL full_vld c=%0d got=%b want=%b", c, vld_o, eg); end
            $display("full drain c=%0d vld=%b", c, vld_o);
            next_cycle();
        end
        vld_i = 1'b0;
    endtask

    // With the FIFO full, a response and a new grant share one cycle.
    task automatic test_full_push_pop();
        logic [3:0] eg;
        for (int c = 0; c < 2; c++) begin
            req_i = 4'b1 << c; gnt_i = 1'b1; vld_i = 1'b0;
            @(negedge clk_i);
            n_cmp++; if (gnt_o !== (4'b1 << c)) begin n_bad++; $display("FAIL pp_fill c=%0d got=%b want=%b", c, gnt_o, 4'b1 << c); end
            id_q.push_back(c);
            next_cycle();
        end
        req_i = 4'b0100; gnt_i = 1'b1; vld_i = 1'b1;
        @(negedge clk_i);
        eg = 4'b1 << id_q.pop_front();
        n_cmp++; if (vld_o !== eg) begin n_bad++; $display("FAIL pp_vld got=%b want=%b", vld_o, eg); end
        n_cmp++; if (gnt_o !== 4'b0100) begin n_bad++; $display("FAIL pp_gnt got=%b want=0100", gnt_o); end
        id_q.push_back(2);
        $display("pp same-cycle gnt=%b vld=%b", gnt_o, vld_o);
        next_cycle();
        req_i = 4'b1000; vld_i = 1'b0;
        @(negedge clk_i);
        n_cmp++; if (req_o !== 1'b0) begin n_bad++; $display("FAIL pp_still_full got=%b want=0", req_o); end
        next_cycle();
        for (int c = 0; c < 2; c++) begin
            req_i = '0; gnt_i = 1'b0; vld_i = 1'b1;
            @(negedge clk_i);
            eg = 4'b1 << id_q.pop_front();
            n_cmp++; if (vld_o !== eg) begin n_bad++; $display("FAIL pp_drain c=%0d got=%b want=%b", c, vld_o, eg); end
            $display("pp drain c=%0d vld=%b", c, vld_o);
            next_cycle();
        end
        vld_i = 1'b0;
    endtask

    // Reset with grants in flight discards them and restarts priority at 0.
    task automatic test_reset_mid();
        logic [3:0] rq [2];
        rq = '{4'b1000, 4'b0001};
        for (int c = 0; c < 2; c++) begin
            req_i = rq[c]; gnt_i = 1'b1; vld_i = 1'b0;
            @(negedge clk_i);
            n_cmp++; if (gnt_o !== rq[c]) begin n_bad++; $display("FAIL rm_fill c=%0d got=%b want=%b", c, gnt_o, rq[c]); end
            next_cycle();
        end
        req_i = '0; gnt_i = 1'b0; rst_ni = 1'b0;
        id_q.delete();
        @(negedge clk_i);
        n_cmp++; if ({req_o, gnt_o, vld_o} !== 9'b0) begin n_bad++; $display("FAIL rm_in_reset got=%b want=0", {req_o, gnt_o, vld_o}); end
        next_cycle();
        rst_ni = 1'b1; vld_i = 1'b1;
        @(negedge clk_i);
        n_cmp++; if (vld_o !== 4'b0) begin n_bad++; $display("FAIL rm_orphan got=%b want=0000", vld_o); end
        $display("rm orphan vld=%b", vld_o);
        next_cycle();
        vld_i = 1'b0; req_i = 4'hF; gnt_i = 1'b1;
        @(negedge clk_i);
        n_cmp++; if (gnt_o !== 4'b0001) begin n_bad++; $display("FAIL rm_restart got=%b want=0001", gnt_o); end
        id_q.push_back(0);
        $display("rm restart gnt=%b", gnt_o);
        next_cycle();
        req_i = '0; gnt_i = 1'b0; vld_i = 1'b1;
        @(negedge clk_i);
        n_cmp++; if (vld_o !== (4'b1 << id_q.pop_front())) begin n_bad++; $display("FAIL rm_resp got=%b want=0001", vld_o); end
        next_cycle();
        vld_i = 1'b0;
    endtask

    // Single master, bank latency 3, back-to-back requests.
    task automatic test_single();
        int gpat [9];
        logic eg, ev;
        gpat = '{1, 1, 0, 1, 1, 1, 0, 0, 0};
        for (int c = 0; c < 9; c++) begin
            s_req_i = (c < 6) ? 1'b1 : 1'b0;
            s_gnt_i = gpat[c] != 0;
            s_vld_i = (c >= 3) && (gpat[c - 3] != 0);
            s_data_i[0] = 32'(32'h5000_0000 + c);
            s_rdata_i = 32'(32'hBEEF_0000 + c);
            @(negedge clk_i);
            eg = (c < 6) && (gpat[c] != 0);
            ev = 1'b0;
            if (s_vld_i && sq.size() > 0) begin void'(sq.pop_front()); ev = 1'b1; end
            n_cmp++; if (s_gnt_o !== eg) begin n_bad++; $display("FAIL single_gnt c=%0d got=%b want=%b", c, s_gnt_o, eg); end
            n_cmp++; if (s_req_o !== (c < 6)) begin n_bad++; $display("FAIL single_req c=%0d got=%b want=%b", c, s_req_o, (c < 6)); end
            n_cmp++; if (s_vld_o !== ev) begin n_bad++; $display("FAIL single_vld c=%0d got=%b want=%b", c, s_vld_o, ev); end
            n_cmp++; if (s_rdata_o[0] !== 32'(32'hBEEF_0000 + c)) begin n_bad++; $display("FAIL single_rdata c=%0d got=%h", c, s_rdata_o[0]); end
            n_cmp++; if (s_data_o !== 32'(32'h5000_0000 + c)) begin n_bad++; $display("FAIL single_data c=%0d got=%h", c, s_data_o); end
            if (eg) sq.push_back(c);
            $display("single c=%0d gnt=%b vld=%b", c, s_gnt_o, s_vld_o);
            next_cycle();
        end
        s_req_i = '0; s_gnt_i = 1'b0; s_vld_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_hold_priority();
        test_full();
        test_full_push_pop();
        test_reset_mid();
        test_single();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/bank_arb_resp_demux_varlat.md
BANK_ARB_RESP_DEMUX_VARLAT -- requirements
Module: bank_arb_resp_demux_varlat

Interface
REQ-001 Parameter NumIn, default 4: number of master ports competing for this bank, >=1.
REQ-002 Parameter ReqDataWidth, default 32: request payload width.
REQ-003 Parameter RespDataWidth, default 32: response payload width.
REQ-004 Parameter MaxOutstanding, default 2: outstanding granted transactions tracked, power of two, >=1.
REQ-005 Parameter LogNumIn, default NumIn>1 ? $clog2(NumIn) : 1: master index width.
REQ-006 clk_i  input  1  sole clock; all state on rising edge.
REQ-007 rst_ni  input  1  reset, asynchronous, active-low.
REQ-008 req_i  input  NumIn  per-master request.
REQ-009 data_i  input  NumIn x ReqDataWidth  per-master request payload.
REQ-010 gnt_o  output  NumIn  per-master grant.
REQ-011 vld_o  output  NumIn  per-master response valid.
REQ-012 rdata_o  output  NumIn x RespDataWidth  response data, broadcast to all masters.
REQ-013 req_o  output  1  request to bank.
REQ-014 gnt_i  input  1  bank grant.
REQ-015 data_o  output  ReqDataWidth  payload of arbitration winner.
REQ-016 vld_i  input  1  bank response valid, in order, >=1 cycle after its grant.
REQ-017 rdata_i  input  RespDataWidth  bank response data.

Function
REQ-018 Arbitration round-robin: winner = first asserted req_i at or after rr_q, wrapping NumIn-1 -> 0.
REQ-019 Accept condition: fifo not full, or full with a pop in the same cycle.
REQ-020 req_o = |req_i & accept; data_o = data_i[winner]; both combinational, no added latency.
REQ-021 gnt_o[winner] = req_o & gnt_i; all other gnt_o bits 0; at most one gnt_o bit high per cycle.
REQ-022 Handshake (req_o & gnt_i): push winner index into ID fifo; rr_q <= (winner+1) mod NumIn next cycle.
REQ-023 No handshake: rr_q holds; a master keeping req_i high keeps its priority position.
REQ-024 Response: vld_i & fifo non-empty -> vld_o[head] = 1 same cycle, fifo pops; other vld_o bits 0.
REQ-025 rdata_o[k] = rdata_i for every k, combinational.
REQ-026 vld_i with fifo empty: dropped (all vld_o 0); simulation-only assertion flags it.
REQ-027 Push and pop in the same cycle legal at any occupancy, including full; occupancy unchanged.
REQ-028 Full fifo without pop: req_o = 0, all gnt_o = 0; masters keep requesting.
REQ-029 Fifo pointers wrap modulo MaxOutstanding; occupancy counter width $clog2(MaxOutstanding)+1.
REQ-030 NumIn == 1: arbiter bypassed, winner fixed 0, rr_q unused; fifo behaviour unchanged.
REQ-031 Responses return to masters in grant order; no reordering.

Reset
REQ-032 rst_ni low: rr_q = 0, fifo empty, read/write pointers 0, asynchronously.
REQ-033 During reset, given all inputs low: gnt_o, vld_o, req_o = 0; data_o/rdata_o follow inputs.
REQ-034 Reset mid-transaction discards all outstanding IDs; later bank vld_i falls under REQ-026.

Structure
REQ-035 No shared package; widths are local parameters derived from module parameters.
REQ-036 One sub-module, varlat_id_fifo (LogNumIn wide, MaxOutstanding deep, full/empty, push/pop); arbiter inline.
REQ-037 Simulation-only assertions: NumIn>0, MaxOutstanding power of two, REQ-026, one-hot-or-zero gnt_o and vld_o.

Verification
REQ-038 NumIn=4, req_i=4'b1111, gnt_i=1 continuous, bank latency 1 -> grants to 0,1,2,3,0; vld_o follows 1 cycle after each.
REQ-039 req_i=4'b0100 only, gnt_i=0 for 3 cycles then 1 -> gnt_o=4'b0100 on 4th cycle only; rr_q becomes 3.
REQ-040 MaxOutstanding=2, two grants (masters 1,3), no vld_i -> req_o=0 on 3rd request; vld_i then pops: vld_o=4'b0010, then 4'b1000.
REQ-041 Full fifo, vld_i and new request (master 2) same cycle -> vld_o to head master and gnt_o=4'b0100 same cycle; occupancy stays 2.
REQ-042 Two outstanding grants, rst_ni low 1 cycle, then vld_i=1 -> vld_o=0, assertion fires, req_o/gnt_o restart from master 0.
REQ-043 NumIn=1, latency 3, back-to-back requests -> gnt_o follows gnt_i, vld_o[0]=vld_i, rdata_o[0]=rdata_i.
